// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: pixel request / video output bus between the timing
// generator (master) and the pixel source / display sink (slave).
interface video_timing_gen_if #(
   parameter int CNT_W  = 12,
   parameter int DATA_W = 24
);
   logic              data_req;
   logic [CNT_W-1:0]  pixel_xpos;
   logic [CNT_W-1:0]  pixel_ypos;
   logic [DATA_W-1:0] pixel_data;
   logic              video_hs;
   logic              video_vs;
   logic              video_de;
   logic [DATA_W-1:0] video_rgb;
   logic              frame_start;
   logic              line_start;

   modport master (
      output data_req, pixel_xpos, pixel_ypos, video_hs, video_vs, video_de,
             video_rgb, frame_start, line_start,
      input  pixel_data
   );

   modport slave (
      input  data_req, pixel_xpos, pixel_ypos, video_hs, video_vs, video_de,
             video_rgb, frame_start, line_start,
      output pixel_data
   );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator. Issues pixel requests REQ_LEAD
// cycles ahead of video_de, and swaps in new h/v timing only at a frame
// boundary after validating it. Optional colour-bar source: VTG_PATTERN_EN.
// Every output is a registered decode of the counters, so outputs trail the
// counter phase by one cycle; relative timing between outputs is exact.
module video_timing_gen #(
   parameter int CNT_W    = 12,
   parameter int DATA_W   = 24,
   parameter int REQ_LEAD = 2,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int H_DISP   = 800,
   parameter int H_TOTAL  = 1056,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 21,
   parameter int V_DISP   = 480,
   parameter int V_TOTAL  = 505
) (
   input  logic               pixel_clk,
   input  logic               sys_rst,
   input  logic [4*CNT_W-1:0] cfg_h,
   input  logic [4*CNT_W-1:0] cfg_v,
   input  logic               cfg_load,
`ifdef VTG_PATTERN_EN
   input  logic               pattern_en,
`endif
   output logic               cfg_err,
   video_timing_gen_if.master vif
);
   // Two guard bits so sync+back+disp and counter+lead never wrap.
   localparam int CW = CNT_W + 2;

   typedef struct packed {
      logic [CNT_W-1:0] total;
      logic [CNT_W-1:0] disp;
      logic [CNT_W-1:0] back;
      logic [CNT_W-1:0] sync;
   } timing_t;

   localparam timing_t DEF_H = timing_t'({CNT_W'(H_TOTAL), CNT_W'(H_DISP),
                                          CNT_W'(H_BACK), CNT_W'(H_SYNC)});
   localparam timing_t DEF_V = timing_t'({CNT_W'(V_TOTAL), CNT_W'(V_DISP),
                                          CNT_W'(V_BACK), CNT_W'(V_SYNC)});

   timing_t           act_h, act_v, pend_h, pend_v;
   logic              pend;
   logic [CNT_W-1:0]  cnt_h, cnt_v;
   logic [CW-1:0]     h_pos, h_req, h_beg, h_end, v_pos, v_beg, v_end;
   logic              line_end, frame_end, v_active, req_win, set_ok;
   logic              data_req_q, hs_q, vs_q, fs_q, ls_q, err_q;
   logic [CNT_W-1:0]  xpos_q, ypos_q;
   logic [REQ_LEAD:1] vld_pipe;

   function automatic logic valid_set(timing_t t);
      logic [CW-1:0] sb;
      sb = CW'(t.sync) + CW'(t.back);
      return (t.disp != '0) && (t.sync != '0) &&
             ((sb + CW'(t.disp)) <= CW'(t.total)) && (sb >= CW'(REQ_LEAD));
   endfunction

   // Window decode of the current counter phase against the active set.
   always_comb begin
      h_pos     = CW'(cnt_h);
      v_pos     = CW'(cnt_v);
      h_req     = h_pos + CW'(REQ_LEAD);
      h_beg     = CW'(act_h.sync) + CW'(act_h.back);
      h_end     = h_beg + CW'(act_h.disp);
      v_beg     = CW'(act_v.sync) + CW'(act_v.back);
      v_end     = v_beg + CW'(act_v.disp);
      line_end  = (h_pos + CW'(1)) == CW'(act_h.total);
      frame_end = line_end && ((v_pos + CW'(1)) == CW'(act_v.total));
      v_active  = (v_pos >= v_beg) && (v_pos < v_end);
      req_win   = v_active && (h_req >= h_beg) && (h_req < h_end);
      set_ok    = valid_set(pend_h) && valid_set(pend_v);
   end

   // Pending/active timing sets; a load on the apply cycle waits a frame.
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         act_h  <= DEF_H;
         act_v  <= DEF_V;
         pend_h <= '0;
         pend_v <= '0;
         pend   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (frame_end && pend) begin
            if (set_ok) begin
               act_h <= pend_h;
               act_v <= pend_v;
            end else begin
               err_q <= 1'b1;
            end
         end
         if (cfg_load) begin
            pend_h <= timing_t'(cfg_h);
            pend_v <= timing_t'(cfg_v);
            pend   <= 1'b1;
         end else if (frame_end) begin
            pend   <= 1'b0;
         end
      end
   end

   // Horizontal/vertical raster counters.
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         cnt_h <= '0;
         cnt_v <= '0;
      end else if (line_end) begin
         cnt_h <= '0;
         cnt_v <= frame_end ? '0 : cnt_v + 1'b1;
      end else begin
         cnt_h <= cnt_h + 1'b1;
      end
   end

   // Registered sync/request/position outputs and the de delay line.
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         data_req_q <= 1'b0;
         xpos_q     <= '0;
         ypos_q     <= '0;
         hs_q       <= 1'(HS_POL);
         vs_q       <= 1'(VS_POL);
         fs_q       <= 1'b0;
         ls_q       <= 1'b0;
         vld_pipe   <= '0;
      end else begin
         data_req_q <= req_win;
         xpos_q     <= !req_win ? '0 : (data_req_q ? xpos_q + 1'b1 : '0);
         ypos_q     <= v_active ? CNT_W'(v_pos - v_beg) : '0;
         hs_q       <= (h_pos < CW'(act_h.sync)) ? 1'(HS_POL) : ~1'(HS_POL);
         vs_q       <= (v_pos < CW'(act_v.sync)) ? 1'(VS_POL) : ~1'(VS_POL);
         ls_q       <= (cnt_h == '0);
         fs_q       <= (cnt_h == '0) && (cnt_v == '0);
         vld_pipe[1] <= data_req_q;
         for (int i = 2; i <= REQ_LEAD; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

`ifdef VTG_PATTERN_EN
   localparam int CH = DATA_W / 3;
   logic [REQ_LEAD:1][CNT_W-1:0] xpos_pipe;
   logic [CW-1:0]                bar_w;
   logic [2:0]                   bar_idx;
   logic [DATA_W-1:0]            bar_rgb;

   // xpos delayed to line up with video_de.
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         xpos_pipe <= '0;
      end else begin
         xpos_pipe[1] <= xpos_q;
         for (int i = 2; i <= REQ_LEAD; i++) xpos_pipe[i] <= xpos_pipe[i-1];
      end
   end

   // Bar index by threshold compare; bit pattern of the index gives ~{g,r,b}.
   always_comb begin
      bar_w   = CW'(act_h.disp >> 3);
      bar_idx = '0;
      for (int k = 1; k < 8; k++)
         if (CW'(xpos_pipe[REQ_LEAD]) >= CW'(k) * bar_w) bar_idx = 3'(k);
      bar_rgb = DATA_W'({{CH{~bar_idx[1]}}, {CH{~bar_idx[2]}}, {CH{~bar_idx[0]}}});
   end

   assign vif.video_rgb = !vld_pipe[REQ_LEAD] ? '0 :
                          (pattern_en ? bar_rgb : vif.pixel_data);
`else
   assign vif.video_rgb = vld_pipe[REQ_LEAD] ? vif.pixel_data : '0;
`endif

   assign vif.data_req    = data_req_q;
   assign vif.pixel_xpos  = xpos_q;
   assign vif.pixel_ypos  = ypos_q;
   assign vif.video_hs    = hs_q;
   assign vif.video_vs    = vs_q;
   assign vif.video_de    = vld_pipe[REQ_LEAD];
   assign vif.frame_start = fs_q;
   assign vif.line_start  = ls_q;
   assign cfg_err         = err_q;
endmodule
